// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive packer.
// Holds the parity-mode encodings, the receiver FSM state type and a
// helper that computes the expected parity bit for a received byte.
package uart_pkg;

  localparam int unsigned ParityNone = 0;
  localparam int unsigned ParityOdd  = 1;
  localparam int unsigned ParityEven = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_state_e;

  // Parity bit the transmitter should have sent for this byte.
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
    return (mode == ParityOdd) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator for the UART receiver.
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   restart_i synchronous restart; the next tick comes DIV clocks later
//   tick_o    one-clock pulse every DIV clocks
module uart_baud_tick #(
  parameter int unsigned DIV = 325
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wrap;

  always_comb begin
    wrap   = (cnt_q == CntW'(DIV - 1));
    tick_o = wrap && !restart_i;
    if (restart_i || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_packer.sv
// UART receive front end that packs bytes into FIFO write words.
// Oversamples rx with a 3-sample majority vote, optionally checks parity,
// checks framing and packs FIFO_WR_BYTE bytes (first byte in the MSBs) into
// one FIFO word. An idle timeout flushes a partial word, left-aligned.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   rx                serial input (asynchronous)
//   fifo_full         FIFO full flag, sampled in the write cycle
//   fifo_wr_data      packed word
//   fifo_wr_en        one-cycle write strobe
//   fifo_wr_partial   qualifies fifo_wr_en: timeout flush, zero-padded LSBs
//   frame_err         pulse: stop bit sampled 0
//   parity_err        pulse: parity mismatch
//   overflow          pulse: word dropped because fifo_full was high
module uart_rx_packer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned UART_BPS      = 9600,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned FIFO_WR_BYTE  = 4,
  parameter int unsigned FIFO_WR_WIDTH = 32,
  parameter int unsigned IDLE_TIMEOUT  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  input  logic                     fifo_full,
  output logic [FIFO_WR_WIDTH-1:0] fifo_wr_data,
  output logic                     fifo_wr_en,
  output logic                     fifo_wr_partial,
  output logic                     frame_err,
  output logic                     parity_err,
  output logic                     overflow
);

  localparam int unsigned Div       = CLK_FREQ / (UART_BPS * OVERSAMPLE);
  localparam int unsigned SampW     = $clog2(OVERSAMPLE);
  localparam int unsigned IdleLimit = IDLE_TIMEOUT * OVERSAMPLE;
  localparam int unsigned IdleW     = (IdleLimit > 0) ? $clog2(IdleLimit + 1) : 1;
  localparam int unsigned CntW      = $clog2(FIFO_WR_BYTE + 1);

  // samp_q counts ticks already seen in the current bit, so the tick being
  // processed is number samp_q+1; votes at OS/2-1, OS/2, decision at OS/2+1.
  localparam logic [SampW-1:0] SampVote0  = SampW'(OVERSAMPLE / 2 - 2);
  localparam logic [SampW-1:0] SampVote1  = SampW'(OVERSAMPLE / 2 - 1);
  localparam logic [SampW-1:0] SampDecide = SampW'(OVERSAMPLE / 2);
  localparam logic [SampW-1:0] SampLast   = SampW'(OVERSAMPLE - 1);

  // rx synchroniser plus one history flop for falling-edge detection
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  uart_state_e state_q, state_d;
  logic [SampW-1:0] samp_q, samp_d;
  logic [1:0]       ones_q, ones_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             bad_q, bad_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             start_edge, tick, bit_vote, byte_ok;

  assign start_edge = (state_q == StIdle) && rx_prev_q && !rx_s2_q;

  uart_baud_tick #(
    .DIV(Div)
  ) u_baud_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart_i(start_edge),
    .tick_o   (tick)
  );

  always_comb begin
    state_d      = state_q;
    samp_d       = samp_q;
    ones_d       = ones_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    bad_d        = bad_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    byte_ok      = 1'b0;
    // ones_q holds the count of 1s among the first two samples (0..2)
    bit_vote     = ones_q[1] | (ones_q[0] & rx_s2_q);

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d   = StStart;
          samp_d    = '0;
          ones_d    = '0;
          bit_cnt_d = '0;
          bad_d     = 1'b0;
        end
      end
      StBreak: begin
        if (rx_s2_q) begin
          state_d = StIdle;
        end
      end
      StStart, StData, StParity, StStop: begin
        if (tick) begin
          samp_d = (samp_q == SampLast) ? '0 : samp_q + SampW'(1);
          if (samp_q == SampVote0 || samp_q == SampVote1) begin
            ones_d = ones_q + {1'b0, rx_s2_q};
          end
          if (samp_q == SampDecide) begin
            ones_d = '0;
            // Next state is entered mid-bit; samp keeps running so its first
            // decision lands in the middle of the following bit.
            unique case (state_q)
              StStart: state_d = bit_vote ? StIdle : StData;
              StData: begin
                shift_d   = {bit_vote, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                  state_d = (PARITY != ParityNone) ? StParity : StStop;
                end
              end
              StParity: begin
                if (bit_vote != parity_bit(shift_q, PARITY)) begin
                  parity_err_d = 1'b1;
                  bad_d        = 1'b1;
                end
                state_d = StStop;
              end
              default: begin
                if (bit_vote) begin
                  byte_ok = !bad_q;
                  state_d = StIdle;
                end else begin
                  frame_err_d = 1'b1;
                  state_d     = StBreak;
                end
              end
            endcase
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Packer and idle timeout
  logic [FIFO_WR_WIDTH-1:0] word_q, word_d, word_next;
  logic [FIFO_WR_WIDTH-1:0] data_q, data_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [IdleW-1:0]         idle_q, idle_d;
  logic                     pend_q, pend_d;
  logic                     partial_q, partial_d;
  logic                     timeout;

  always_comb begin
    word_d    = word_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    pend_d    = 1'b0;
    partial_d = 1'b0;
    idle_d    = idle_q;
    word_next = (word_q << 8) | FIFO_WR_WIDTH'(shift_q);

    if (start_edge) begin
      idle_d = '0;
    end else if (tick && idle_q != IdleW'(IdleLimit)) begin
      idle_d = idle_q + IdleW'(1);
    end

    // A start edge in the expiry cycle wins over the flush.
    timeout = (IdleLimit != 0) && (idle_q == IdleW'(IdleLimit)) && (state_q == StIdle) &&
              (cnt_q != '0) && !start_edge;

    if (byte_ok) begin
      if (cnt_q == CntW'(FIFO_WR_BYTE - 1)) begin
        pend_d = 1'b1;
        data_d = word_next;
        word_d = '0;
        cnt_d  = '0;
      end else begin
        word_d = word_next;
        cnt_d  = cnt_q + CntW'(1);
      end
    end else if (timeout) begin
      pend_d    = 1'b1;
      partial_d = 1'b1;
      data_d    = word_q << (8 * (FIFO_WR_BYTE - int'(cnt_q)));
      word_d    = '0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      samp_q       <= '0;
      ones_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      bad_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      word_q       <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      idle_q       <= '0;
      pend_q       <= 1'b0;
      partial_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      samp_q       <= samp_d;
      ones_q       <= ones_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      bad_q        <= bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      word_q       <= word_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      idle_q       <= idle_d;
      pend_q       <= pend_d;
      partial_q    <= partial_d;
    end
  end

  // fifo_full is honoured in the write cycle itself, hence the gating here.
  assign fifo_wr_data    = data_q;
  assign fifo_wr_en      = pend_q && !fifo_full;
  assign overflow        = pend_q && fifo_full;
  assign fifo_wr_partial = pend_q && !fifo_full && partial_q;
  assign frame_err       = frame_err_q;
  assign parity_err      = parity_err_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Scoreboard bench for uart_rx_packer: a no-parity instance and an
// even-parity instance share clock and reset. Baud rate is raised so that
// one bit is 128 clocks, keeping the run short.
module tb_uart_rx_packer;

  localparam int unsigned ClkFreq = 50_000_000;
  localparam int unsigned Bps     = 390_625;  // 50 MHz / (Bps*16) = 8 clocks per tick
  localparam int          Bit     = 128;

  typedef struct packed {
    logic        ovf;
    logic        partial;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic full0 = 1'b0, full1 = 1'b0;
  logic [31:0] data0, data1;
  logic wr0, wr1, part0, part1, ferr0, ferr1, perr0, perr1, ovf0, ovf1;

  always #5 clk = ~clk;

  uart_rx_packer #(
    .CLK_FREQ(ClkFreq), .UART_BPS(Bps), .OVERSAMPLE(16), .PARITY(0),
    .FIFO_WR_BYTE(4), .FIFO_WR_WIDTH(32), .IDLE_TIMEOUT(32)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .fifo_full(full0),
    .fifo_wr_data(data0), .fifo_wr_en(wr0), .fifo_wr_partial(part0),
    .frame_err(ferr0), .parity_err(perr0), .overflow(ovf0)
  );

  uart_rx_packer #(
    .CLK_FREQ(ClkFreq), .UART_BPS(Bps), .OVERSAMPLE(16), .PARITY(2),
    .FIFO_WR_BYTE(4), .FIFO_WR_WIDTH(32), .IDLE_TIMEOUT(32)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .fifo_full(full1),
    .fifo_wr_data(data1), .fifo_wr_en(wr1), .fifo_wr_partial(part1),
    .frame_err(ferr1), .parity_err(perr1), .overflow(ovf1)
  );

  int checks = 0;
  int errors = 0;
  exp_t exp0[$];
  exp_t exp1[$];
  logic [31:0] m_word[2];
  int m_cnt[2];
  int ferr_cnt[2];
  int perr_cnt[2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int sel, input logic ovf, input logic partial,
                          input logic [31:0] data);
    exp_t e;
    e.ovf = ovf;
    e.partial = partial;
    e.data = data;
    if (sel == 0) exp0.push_back(e);
    else exp1.push_back(e);
  endtask

  function automatic int q_size(input int sel);
    return (sel == 0) ? exp0.size() : exp1.size();
  endfunction

  // Reference packer: first byte ends in the MSBs.
  task automatic model_byte(input int sel, input logic [7:0] b);
    m_word[sel] = {m_word[sel][23:0], b};
    m_cnt[sel]++;
    if (m_cnt[sel] == 4) begin
      push_exp(sel, (sel == 0) ? full0 : full1, 1'b0, m_word[sel]);
      m_word[sel] = '0;
      m_cnt[sel] = 0;
    end
  endtask

  task automatic model_flush(input int sel);
    push_exp(sel, 1'b0, 1'b1, m_word[sel] << (8 * (4 - m_cnt[sel])));
    m_word[sel] = '0;
    m_cnt[sel] = 0;
  endtask

  task automatic mon(input int sel, input logic wr, input logic ovf, input logic part,
                     input logic [31:0] data, input logic ferr, input logic perr);
    exp_t e;
    if (ferr) ferr_cnt[sel]++;
    if (perr) perr_cnt[sel]++;
    if (wr || ovf) begin
      if (q_size(sel) == 0) begin
        check_eq($sformatf("unexpected_out%0d", sel), {62'd0, wr, ovf}, 64'd0);
      end else begin
        if (sel == 0) e = exp0.pop_front();
        else e = exp1.pop_front();
        check_eq($sformatf("overflow%0d", sel), ovf, e.ovf);
        check_eq($sformatf("wr_en%0d", sel), wr, !e.ovf);
        if (!e.ovf) begin
          check_eq($sformatf("wr_data%0d", sel), data, e.data);
          check_eq($sformatf("wr_partial%0d", sel), part, e.partial);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, wr0, ovf0, part0, data0, ferr0, perr0);
      mon(1, wr1, ovf1, part1, data1, ferr1, perr1);
    end
  end

  task automatic drive(input int sel, input logic v, input int clks);
    if (sel == 0) rx0 = v;
    else rx1 = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  // Instance 1 expects an even parity bit; bad_par inverts it.
  task automatic send_frame(input int sel, input logic [7:0] b, input bit bad_par,
                            input bit stop_val, input int bp);
    drive(sel, 1'b0, bp);
    for (int i = 0; i < 8; i++) drive(sel, b[i], bp);
    if (sel == 1) drive(sel, (^b) ^ bad_par, bp);
    if (!bad_par && stop_val) model_byte(sel, b);
    drive(sel, stop_val, bp);
  endtask

  task automatic send_word(input int sel, input logic [31:0] w, input int bp);
    for (int i = 3; i >= 0; i--) send_frame(sel, w[8*i +: 8], 1'b0, 1'b1, bp);
  endtask

  task automatic drain(input string tag, input int sel, input int max_clks);
    for (int i = 0; i < max_clks; i++) begin
      if (q_size(sel) == 0) break;
      @(posedge clk);
    end
    #1;
    check_eq(tag, q_size(sel), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check_eq({tag, "_wr_en"}, wr0, 0);
    check_eq({tag, "_data"}, data0, 0);
    check_eq({tag, "_partial"}, part0, 0);
    check_eq({tag, "_frame_err"}, ferr0, 0);
    check_eq({tag, "_parity_err"}, perr0, 0);
    check_eq({tag, "_overflow"}, ovf0, 0);
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench timed out");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      m_word[s] = '0;
      m_cnt[s] = 0;
      ferr_cnt[s] = 0;
      perr_cnt[s] = 0;
    end
    repeat (4) @(posedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 1'b1, 20);

    // Plain four-byte word
    send_word(0, 32'h12345678, Bit);
    drain("s1_drain", 0, 200);

    // Even parity: bad parity on 0xA5 is dropped, then a good word
    send_frame(1, 8'hA5, 1'b1, 1'b1, Bit);
    send_word(1, 32'h01020304, Bit);
    drain("s2_drain", 1, 200);
    check_eq("s2_parity_err", perr_cnt[1], 1);

    // Stop bit 0: frame error, byte dropped, line idle, then a good word
    send_frame(0, 8'hFF, 1'b0, 1'b0, Bit);
    drive(0, 1'b1, 3 * Bit);
    send_word(0, 32'h11223344, Bit);
    drain("s3_drain", 0, 200);
    check_eq("s3_frame_err", ferr_cnt[0], 1);

    // Short low glitch: false start, nothing reported
    drive(0, 1'b0, 24);
    drive(0, 1'b1, 3 * Bit);
    check_eq("s4_frame_err", ferr_cnt[0], 1);
    check_eq("s4_parity_err", perr_cnt[0], 0);
    check_eq("s4_no_write", q_size(0), 0);

    // Two bytes then idle: partial flush, not before the timeout
    send_frame(0, 8'hAB, 1'b0, 1'b1, Bit);
    send_frame(0, 8'hCD, 1'b0, 1'b1, Bit);
    model_flush(0);
    drive(0, 1'b1, 15 * Bit);
    check_eq("s5_not_early", q_size(0), 1);
    drain("s5_flush", 0, 30 * Bit);

    // FIFO full at word completion: overflow, then a normal word
    send_frame(0, 8'h21, 1'b0, 1'b1, Bit);
    send_frame(0, 8'h43, 1'b0, 1'b1, Bit);
    send_frame(0, 8'h65, 1'b0, 1'b1, Bit);
    full0 = 1'b1;
    send_frame(0, 8'h87, 1'b0, 1'b1, Bit);
    drain("s6_ovf", 0, 200);
    full0 = 1'b0;
    send_word(0, 32'hCAFE0042, Bit);
    drain("s6_after", 0, 200);

    // Reset mid byte: partial byte and partial word are lost
    send_frame(0, 8'h9A, 1'b0, 1'b1, Bit);
    send_frame(0, 8'hBC, 1'b0, 1'b1, Bit);
    drive(0, 1'b0, Bit);
    drive(0, 1'b1, Bit);
    drive(0, 1'b0, Bit / 2);
    rst_n = 1'b0;
    check_idle_outputs("s7_reset");
    rx0 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_word[0] = '0;
    m_cnt[0] = 0;
    drive(0, 1'b1, 2 * Bit);
    send_word(0, 32'hDEADBEEF, Bit);
    drain("s7_drain", 0, 200);

    // Bit period skewed by about +/-2%
    send_word(0, 32'h5A3C96E1, Bit + 3);
    drain("s8_slow", 0, 200);
    send_word(0, 32'h0FF0A55A, Bit - 3);
    drain("s8_fast", 0, 200);

    check_eq("end_frame_err0", ferr_cnt[0], 1);
    check_eq("end_parity_err0", perr_cnt[0], 0);
    check_eq("end_frame_err1", ferr_cnt[1], 0);
    check_eq("end_parity_err1", perr_cnt[1], 1);
    check_eq("end_queue1", q_size(1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
